// File: rtl/alu_fpga_ctrl.sv
// Board front-end for an external ALU: debounced keys step operand/opcode capture, result shown on hex digits.
// Define ALU_FPGA_BLANK_EN to blank leading-zero digits of the current display window.

module alu_fpga_debounce #(
   parameter int DEB_CYCLES = 16
) (
   input  logic CLK,
   input  logic nRST,
   input  logic key_n,
   output logic press
);
   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic [1:0]    sync;
   logic          stable;
   logic [CW-1:0] cnt;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         sync   <= 2'b11;
         stable <= 1'b1;
         cnt    <= '0;
         press  <= 1'b0;
      end else begin
         sync  <= {sync[0], key_n};
         press <= 1'b0;
         if (sync[1] == stable) begin
            cnt <= '0;
         end else if (cnt == CW'(DEB_CYCLES - 1)) begin
            // stable==1 here means the key is going down: that is the press
            stable <= ~stable;
            cnt    <= '0;
            press  <= stable;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

module alu_fpga_digit (
   input  logic [3:0] nib,
   input  logic       blank,
   output logic [6:0] seg
);
   always_comb begin
      seg = 7'b1000000;
      case (nib)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b0100111;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         4'hF: seg = 7'b0001110;
         default: seg = 7'b1000000;
      endcase
      if (blank) seg = 7'b1111111;
   end
endmodule

module alu_fpga_ctrl #(
   parameter int DW         = 32,
   parameter int SWW        = 16,
   parameter int NDIG       = 8,
   parameter int DEB_CYCLES = 16
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic [SWW-1:0]    sw_data,
   input  logic              sw_sign,
   input  logic [3:0]        sw_op,
   input  logic [2:0]        key_n,
   output logic [DW-1:0]     alu_portA,
   output logic [DW-1:0]     alu_portB,
   output logic [3:0]        alu_aluop,
   input  logic [DW-1:0]     alu_portOut,
   input  logic [2:0]        alu_flags,
   output logic [7*NDIG-1:0] hex,
   output logic [2:0]        led_state,
   output logic [2:0]        led_flags
);
   localparam int DISP_W = 4 * NDIG;
   localparam int NPAGE  = (DW + DISP_W - 1) / DISP_W;
   localparam int PW     = (NPAGE > 1) ? $clog2(NPAGE) : 1;

   localparam logic [2:0] S_A    = 3'd0;
   localparam logic [2:0] S_B    = 3'd1;
   localparam logic [2:0] S_OP   = 3'd2;
   localparam logic [2:0] S_EXEC = 3'd3;
   localparam logic [2:0] S_SHOW = 3'd4;

   logic [2:0]        press;
   logic [2:0]        state;
   logic [DW-1:0]     opnd;
   logic [DW-1:0]     res;
   logic [PW-1:0]     page;
   logic [DISP_W-1:0] disp;
   logic [DISP_W-1:0] disp_n;
   logic [DISP_W-1:0] res_win;
   logic [NDIG-1:0]   blank;

   for (genvar k = 0; k < 3; k++) begin : g_key
      alu_fpga_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
         .CLK   (CLK),
         .nRST  (nRST),
         .key_n (key_n[k]),
         .press (press[k])
      );
   end

   assign opnd    = sw_sign ? DW'($signed(sw_data)) : DW'(sw_data);
   assign res_win = DISP_W'(res >> (DISP_W * int'(page)));

   always_comb begin
      disp_n = disp;
      case (state)
         S_A, S_B: disp_n = DISP_W'(opnd);
         S_OP:     disp_n = DISP_W'(sw_op);
         S_SHOW:   disp_n = res_win;
         default:  disp_n = disp;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state     <= S_A;
         alu_portA <= '0;
         alu_portB <= '0;
         alu_aluop <= '0;
         res       <= '0;
         led_flags <= '0;
         page      <= '0;
         disp      <= '0;
      end else begin
         disp <= disp_n;
         if (press[1]) begin
            state     <= S_A;
            alu_portA <= '0;
            alu_portB <= '0;
            alu_aluop <= '0;
            res       <= '0;
            led_flags <= '0;
            page      <= '0;
         end else begin
            case (state)
               S_A: if (press[0]) begin
                  alu_portA <= opnd;
                  state     <= S_B;
               end
               S_B: if (press[0]) begin
                  alu_portB <= opnd;
                  state     <= S_OP;
               end
               S_OP: if (press[0]) begin
                  alu_aluop <= sw_op;
                  state     <= S_EXEC;
               end
               S_EXEC: begin
                  res       <= alu_portOut;
                  led_flags <= alu_flags;
                  state     <= S_SHOW;
               end
               S_SHOW: begin
                  if (press[0]) begin
                     state <= S_A;
                     page  <= '0;
                  end else if (press[2]) begin
                     page <= (page == PW'(NPAGE - 1)) ? '0 : page + 1'b1;
                  end
               end
               default: state <= S_A;
            endcase
         end
      end
   end

   assign led_state = {state == S_B, state == S_OP, state == S_SHOW};

   for (genvar i = 0; i < NDIG; i++) begin : g_dig
`ifdef ALU_FPGA_BLANK_EN
      if (i == 0) begin : g_b0
         assign blank[i] = 1'b0;
      end else begin : g_bn
         assign blank[i] = ~|disp[DISP_W-1:4*i];
      end
`else
      assign blank[i] = 1'b0;
`endif
      alu_fpga_digit u_dig (
         .nib   (disp[4*i +: 4]),
         .blank (blank[i]),
         .seg   (hex[7*i +: 7])
      );
   end
endmodule
